// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD nibble correction: add 3 when the digit is 5 or more.
// 4-bit result, no carry out (largest legal input 9 gives 12).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Add-3 correction applied before each left shift
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with level start/done
// handshake, one shift iteration per clock.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st,
  input  logic [IN_W-1:0]           bin,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + IN_W;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shl;
  logic              last;

  // Binary part passes through untouched; each digit field is corrected in parallel
  assign sr_adj[IN_W-1:0] = sr[IN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr[IN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (sr_adj[IN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

  assign sr_shl = sr_adj << 1;
  assign last   = (cnt == CNT_W'(IN_W - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (st)   state_nxt = ST_CONV;
      ST_CONV: if (last) state_nxt = ST_DONE;
      ST_DONE: if (!st)  state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: shift register, iteration counter, result and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sr   <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_CONV);
      case (state)
        ST_IDLE: begin
          if (st) begin
            sr  <= {{BCD_W{1'b0}}, bin};
            cnt <= '0;
          end
        end
        ST_CONV: begin
          sr  <= sr_shl;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            bcd  <= sr_shl[SR_W-1:IN_W];
            done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!st) done <= 1'b0;
        end
        default: begin
          cnt  <= '0;
          sr   <= '0;
          bcd  <= '0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, handshake
// corner sequences and random values against an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.IN_W(16), .DIGITS(5), .CNT_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .bin  (bin),
    .bcd  (bcd),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Decimal digits by plain division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a conversion, follow it to done; reports result, latency, busy count and bcd stability
  task automatic run_conv(input logic [15:0] v, output logic [19:0] res,
                          output int lat, output int bcnt, output logic stable);
    logic [19:0] pre;
    @(negedge clk);
    bin = v;
    st  = 1'b1;
    pre = bcd;
    @(posedge clk); #1;
    lat = 0; bcnt = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (bcd !== pre) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = bcd;
  endtask

  task automatic drop_st();
    @(negedge clk);
    st = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [19:0] res;
    logic [19:0] held;
    int          lat;
    int          bcnt;
    logic        stable;
    logic [15:0] v;

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd65025, 20'h65025};
    vecs[2] = '{16'hFFFF,  20'h65535};
    vecs[3] = '{16'd9,     20'h00009};
    vecs[4] = '{16'd10,    20'h00010};
    vecs[5] = '{16'd1234,  20'h01234};

    rst = 1'b1; st = 1'b0; bin = 16'hABCD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, res, lat, bcnt, stable);
      chk($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd16);
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd16);
      chk($sformatf("vec%0d_stable", i), 32'(stable), 32'd1);
      drop_st();
    end

    // Product of the 8x8 multiplier with both operands 0xFF
    v = 16'(8'hFF * 8'hFF);
    run_conv(v, res, lat, bcnt, stable);
    chk("mult_chain", 32'(res), 32'(ref_bcd(v)));
    drop_st();

    // st held after done: no restart, result held
    run_conv(16'd4321, res, lat, bcnt, stable);
    held = res;
    chk("hold_first", 32'(res), 32'h04321);
    @(negedge clk); bin = 16'd7777;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'(held));
      chk("hold_busy", 32'(busy), 32'd0);
    end
    drop_st();

    // Reset in the middle of a conversion
    @(negedge clk); bin = 16'd40000; st = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk); rst = 1'b1; st = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_conv(16'd1234, res, lat, bcnt, stable);
    chk("postrst_bcd", 32'(res), 32'h01234);
    chk("postrst_lat", 32'(lat), 32'd16);
    drop_st();

    // bin and st disturbed during conversion
    @(negedge clk); bin = 16'd4321; st = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3) begin bin = 16'd9999; st = 1'b0; end
      if (lat == 5) st = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("disturb_bcd", 32'(bcd), 32'h04321);
    chk("disturb_lat", 32'(lat), 32'd16);
    drop_st();

    // Random values against the decimal model
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom_range(0, 65535));
      run_conv(v, res, lat, bcnt, stable);
      chk($sformatf("rnd%0d_%0d", i, v), 32'(res), 32'(ref_bcd(v)));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd16);
      @(negedge clk); st = 1'b0;
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
